// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: upstream framing stage for the DES-S-box hash core.
// Buffers one complete host message, then plays it out to the core one byte
// per cycle with the byte length held on 'counter', and waits for a rising
// edge of the core's hash_ready before accepting the next message.
// Optional build macro: HASH_FEEDER_DIGEST_LATCH_EN adds a registered copy of
// the core digest captured on the WAIT-exit cycle.
module hash_msg_feeder #(
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        M_valid,
    output logic [7:0]  message,
    output logic [63:0] counter,
    input  logic        hash_ready,
    output logic        busy,
    output logic        err_overflow
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
    ,
    input  logic [31:0] digest_in,
    output logic [31:0] digest_q,
    output logic        digest_valid
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    // A count of exactly DEPTH: MSB set, rest clear.
    localparam logic [ADDR_W:0] FULL_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ZERO_C = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_DROP = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [ADDR_W:0] cnt_r, cnt_s;      // bytes stored; also the write address
    logic [ADDR_W:0] rd_r, rd_s;        // bytes played out in SEND
    logic [ADDR_W:0] len_r, len_s;      // length of the message being sent
    logic [7:0]      message_r, message_s;
    logic            m_valid_r, m_valid_s;
    logic            in_ready_r;
    logic            busy_r;
    logic            err_r, err_s;
    logic            hr_q_r;
    logic            wr_en_s;
    logic            done_s;            // digest rise seen while waiting
    logic            accept_s;
    logic            last_beat_s;

    logic [7:0] mem [DEPTH];

    assign accept_s     = in_valid & in_ready_r;
    assign last_beat_s  = (len_r == ZERO_C) || (rd_r == (len_r - ONE_C));

    assign in_ready     = in_ready_r;
    assign M_valid      = m_valid_r;
    assign message      = message_r;
    assign counter      = {{(63-ADDR_W){1'b0}}, len_r};
    assign busy         = busy_r;
    assign err_overflow = err_r;

    // Next-state and next-datapath decode for the framing FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rd_s      = rd_r;
        len_s     = len_r;
        message_s = message_r;
        m_valid_s = 1'b0;
        err_s     = 1'b0;
        wr_en_s   = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    if (!in_empty && (cnt_r == FULL_C)) begin
                        // Too long: drop everything, sink the rest if any.
                        err_s = 1'b1;
                        cnt_s = ZERO_C;
                        if (in_last) begin
                            state_s = ST_FILL;
                        end else begin
                            state_s = ST_DROP;
                        end
                    end else begin
                        if (!in_empty) begin
                            wr_en_s = 1'b1;
                            cnt_s   = cnt_r + ONE_C;
                        end else begin
                            cnt_s   = cnt_r;
                        end
                        if (in_last) begin
                            if (in_empty) begin
                                len_s = cnt_r;
                            end else begin
                                len_s = cnt_r + ONE_C;
                            end
                            rd_s    = ZERO_C;
                            state_s = ST_SEND;
                        end else begin
                            state_s = ST_FILL;
                        end
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DROP: begin
                if (accept_s && in_last) begin
                    cnt_s   = ZERO_C;
                    rd_s    = ZERO_C;
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_SEND: begin
                m_valid_s = 1'b1;
                if (len_r == ZERO_C) begin
                    message_s = 8'h00;
                end else begin
                    message_s = mem[rd_r[ADDR_W-1:0]];
                end
                if (last_beat_s) begin
                    state_s = ST_WAIT;
                end else begin
                    rd_s    = rd_r + ONE_C;
                end
            end
            ST_WAIT: begin
                // Only a fresh rise counts; a level left high is stale.
                if (hash_ready && !hr_q_r) begin
                    done_s  = 1'b1;
                    cnt_s   = ZERO_C;
                    rd_s    = ZERO_C;
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                cnt_s   = ZERO_C;
                rd_s    = ZERO_C;
                state_s = ST_FILL;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered-output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= ZERO_C;
            rd_r       <= ZERO_C;
            len_r      <= ZERO_C;
            message_r  <= 8'h00;
            m_valid_r  <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            hr_q_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            rd_r       <= rd_s;
            len_r      <= len_s;
            message_r  <= message_s;
            m_valid_r  <= m_valid_s;
            in_ready_r <= (state_s == ST_FILL) || (state_s == ST_DROP);
            busy_r     <= (state_s == ST_WAIT);
            err_r      <= err_s;
            hr_q_r     <= hash_ready;
        end
    end

    // Message buffer write port; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[cnt_r[ADDR_W-1:0]] <= in_data;
        end
    end

`ifdef HASH_FEEDER_DIGEST_LATCH_EN
    logic [31:0] digest_q_r;
    logic        digest_valid_r;

    assign digest_q     = digest_q_r;
    assign digest_valid = digest_valid_r;

    // Capture the core digest on the cycle the wait completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_q_r     <= 32'h0000_0000;
            digest_valid_r <= 1'b0;
        end else begin
            if (done_s) begin
                digest_q_r <= digest_in;
            end
            digest_valid_r <= done_s;
        end
    end
`endif

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Scoreboard bench for hash_msg_feeder: dut0 uses the default 64-byte buffer,
// dut1 a 4-byte buffer for overflow and exact-fill cases.
module tb_hash_msg_feeder;

    localparam int K_BUSY = 0, K_RDY = 1, K_MV = 2, K_ERR = 3, K_CNT = 4,
                   K_MSG = 5, K_ACT = 6, K_DQ = 7, K_ERRCNT = 8, K_DVCNT = 9,
                   K_QLEFT = 10;

    typedef struct {int d; logic [7:0] m; logic [63:0] c;} beat_t;
    typedef struct {int d; int n;} run_t;
    typedef struct {int d; int kind; logic [63:0] exp; logic [63:0] act; string name;} chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [7:0]  in_data [2];
    logic        in_last [2];
    logic        in_empty [2];
    logic        M_valid [2];
    logic [7:0]  message [2];
    logic [63:0] counter [2];
    logic        hash_ready [2];
    logic        busy [2];
    logic        err_overflow [2];
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
    logic [31:0] digest_in [2];
    logic [31:0] digest_q [2];
    logic        digest_valid [2];
`endif

    hash_msg_feeder #(.ADDR_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .in_empty(in_empty[0]),
        .M_valid(M_valid[0]), .message(message[0]), .counter(counter[0]),
        .hash_ready(hash_ready[0]), .busy(busy[0]), .err_overflow(err_overflow[0])
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
        , .digest_in(digest_in[0]), .digest_q(digest_q[0]), .digest_valid(digest_valid[0])
`endif
    );

    hash_msg_feeder #(.ADDR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .in_empty(in_empty[1]),
        .M_valid(M_valid[1]), .message(message[1]), .counter(counter[1]),
        .hash_ready(hash_ready[1]), .busy(busy[1]), .err_overflow(err_overflow[1])
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
        , .digest_in(digest_in[1]), .digest_q(digest_q[1]), .digest_valid(digest_valid[1])
`endif
    );

    beat_t bq [$];
    run_t  rq [$];
    chk_t  cq [$];
    int    tests = 0;
    int    fails = 0;
    int    run [2];
    int    err_cnt [2];
    int    dv_cnt [2];
    beat_t mb;
    run_t  mr;
    chk_t  mc;
    logic [63:0] ma;

    function automatic logic [63:0] sample(int d, int kind, logic [63:0] act);
        case (kind)
            K_BUSY:   return {63'd0, busy[d]};
            K_RDY:    return {63'd0, in_ready[d]};
            K_MV:     return {63'd0, M_valid[d]};
            K_ERR:    return {63'd0, err_overflow[d]};
            K_CNT:    return counter[d];
            K_MSG:    return {56'd0, message[d]};
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
            K_DQ:     return {32'd0, digest_q[d]};
`endif
            K_ERRCNT: return 64'(err_cnt[d]);
            K_DVCNT:  return 64'(dv_cnt[d]);
            K_QLEFT:  return 64'(bq.size() + rq.size());
            default:  return act;
        endcase
    endfunction

    // Monitor: pops expected beats/run lengths and queued checks each negedge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (err_overflow[d] === 1'b1) err_cnt[d]++;
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
            if (digest_valid[d] === 1'b1) dv_cnt[d]++;
`endif
            if (M_valid[d] === 1'b1) begin
                run[d]++;
                tests++;
                if (in_ready[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_during_send dut%0d: got %b, want 0", d, in_ready[d]);
                end
                tests++;
                if (bq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat dut%0d: got msg %02h cnt %0d, want no beat",
                             d, message[d], counter[d]);
                end else begin
                    mb = bq.pop_front();
                    if (mb.d != d || message[d] !== mb.m || counter[d] !== mb.c) begin
                        fails++;
                        $display("FAIL beat dut%0d: got msg %02h cnt %0d, want dut%0d msg %02h cnt %0d",
                                 d, message[d], counter[d], mb.d, mb.m, mb.c);
                    end
                end
            end else if (run[d] != 0) begin
                tests++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL run_len dut%0d: got %0d beats, want none", d, run[d]);
                end else begin
                    mr = rq.pop_front();
                    if (mr.d != d || mr.n != run[d]) begin
                        fails++;
                        $display("FAIL run_len dut%0d: got %0d beats, want dut%0d %0d beats",
                                 d, run[d], mr.d, mr.n);
                    end
                end
                run[d] = 0;
            end
        end
        while (cq.size() != 0) begin
            mc = cq.pop_front();
            ma = sample(mc.d, mc.kind, mc.act);
            tests++;
            if (ma !== mc.exp) begin
                fails++;
                $display("FAIL %s dut%0d: got %0h, want %0h", mc.name, mc.d, ma, mc.exp);
            end
        end
    end

    task automatic chk(int d, int kind, logic [63:0] exp, string name, logic [63:0] act = 64'd0);
        chk_t c;
        c.d = d; c.kind = kind; c.exp = exp; c.act = act; c.name = name;
        cq.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int d, logic [7:0] b, logic l, logic e);
        int n = 0;
        in_valid[d] = 1'b1; in_data[d] = b; in_last[d] = l; in_empty[d] = e;
        while (in_ready[d] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk(d, K_ACT, 64'd1, "put_timeout", 64'd0);
        tick();
        in_valid[d] = 1'b0; in_last[d] = 1'b0; in_empty[d] = 1'b0;
    endtask

    // Send n bytes base, base+step, ...; n==0 sends an empty terminator.
    task automatic send_msg(int d, int n, logic [7:0] base, logic [7:0] step, bit sent);
        beat_t b;
        run_t  r;
        logic [7:0] v;
        if (sent) begin
            r.d = d;
            r.n = (n == 0) ? 1 : n;
            rq.push_back(r);
            if (n == 0) begin
                b.d = d; b.m = 8'h00; b.c = 64'd0;
                bq.push_back(b);
            end
            for (int i = 0; i < n; i++) begin
                b.d = d; b.m = 8'(int'(base) + i * int'(step)); b.c = 64'(n);
                bq.push_back(b);
            end
        end
        if (n == 0) begin
            put(d, 8'h00, 1'b1, 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            v = 8'(int'(base) + i * int'(step));
            put(d, v, (i == n - 1) ? 1'b1 : 1'b0, 1'b0);
        end
    endtask

    // Wait for busy, confirm the wait state, then give the core's digest rise.
    task automatic hr_rise(int d, bit keep);
        int n = 0;
        while (busy[d] !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(d, K_ACT, 64'd1, "busy_timeout", (n < 300) ? 64'd1 : 64'd0);
        tick();
        chk(d, K_BUSY, 64'd1, "busy_in_wait");
        chk(d, K_RDY, 64'd0, "ready_in_wait");
        hash_ready[d] = 1'b1;
        tick();
        chk(d, K_BUSY, 64'd0, "busy_clear");
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
        chk(d, K_DQ, {32'd0, digest_in[d]}, "digest_capture");
`endif
        if (!keep) hash_ready[d] = 1'b0;
        tick();
        chk(d, K_RDY, 64'd1, "ready_after_digest");
    endtask

    initial begin
        int n;
        beat_t b;
        run_t  r;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_data[d] = 8'h00; in_last[d] = 1'b0;
            in_empty[d] = 1'b0; hash_ready[d] = 1'b0;
            run[d] = 0; err_cnt[d] = 0; dv_cnt[d] = 0;
        end
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
        digest_in[0] = 32'hC0FF_EE00;
        digest_in[1] = 32'h1234_ABCD;
`endif
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk(d, K_BUSY, 64'd0, "reset_busy");
            chk(d, K_RDY, 64'd0, "reset_ready");
            chk(d, K_MV, 64'd0, "reset_mvalid");
            chk(d, K_ERR, 64'd0, "reset_err");
            chk(d, K_CNT, 64'd0, "reset_counter");
            chk(d, K_MSG, 64'd0, "reset_message");
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) chk(d, K_RDY, 64'd1, "ready_after_reset");

        // "abc"
        send_msg(0, 3, 8'h61, 8'h01, 1'b1);
        hr_rise(0, 1'b0);
        // zero-length; leave hash_ready high so it is stale for the next one
        send_msg(0, 0, 8'h00, 8'h00, 1'b1);
        hr_rise(0, 1'b1);
        // stale level must not complete the wait
        send_msg(0, 2, 8'h11, 8'h11, 1'b1);
        n = 0;
        while (busy[0] !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        repeat (5) tick();
        chk(0, K_BUSY, 64'd1, "stale_level_hold");
        hash_ready[0] = 1'b0;
        tick();
        tick();
        chk(0, K_BUSY, 64'd1, "low_level_hold");
        hr_rise(0, 1'b0);

        // reset during the second beat of a 10-byte message
        b.d = 0; b.m = 8'hA0; b.c = 64'd10;
        bq.push_back(b);
        r.d = 0; r.n = 1;
        rq.push_back(r);
        send_msg(0, 10, 8'hA0, 8'h01, 1'b0);
        n = 0;
        while (M_valid[0] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(0, K_ACT, 64'd1, "mvalid_timeout", (n < 50) ? 64'd1 : 64'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk(0, K_MV, 64'd0, "mvalid_async_drop");
        tick();
        rst_n = 1'b1;
        tick();
        chk(0, K_RDY, 64'd1, "ready_after_midreset");
        chk(0, K_BUSY, 64'd0, "busy_after_midreset");
        send_msg(0, 1, 8'h78, 8'h00, 1'b1);
        hr_rise(0, 1'b0);

        // 4-byte buffer: 5 bytes overflow on the last byte
        send_msg(1, 5, 8'h01, 8'h01, 1'b0);
        repeat (4) tick();
        chk(1, K_ERRCNT, 64'd1, "overflow_pulse");
        chk(1, K_BUSY, 64'd0, "no_send_after_overflow");
        send_msg(1, 2, 8'hAA, 8'h11, 1'b1);
        hr_rise(1, 1'b0);
        // exactly DEPTH bytes
        send_msg(1, 4, 8'h31, 8'h01, 1'b1);
        hr_rise(1, 1'b0);
        // overflow mid-message goes through DROP
        send_msg(1, 6, 8'h41, 8'h01, 1'b0);
        repeat (4) tick();
        chk(1, K_ERRCNT, 64'd2, "drop_overflow");
        send_msg(1, 1, 8'h5A, 8'h00, 1'b1);
        hr_rise(1, 1'b0);

        repeat (4) tick();
        chk(0, K_ERRCNT, 64'd0, "no_overflow_dut0");
        chk(0, K_QLEFT, 64'd0, "scoreboard_drained");
`ifdef HASH_FEEDER_DIGEST_LATCH_EN
        chk(0, K_DVCNT, 64'd4, "digest_valid_count");
        chk(1, K_DVCNT, 64'd3, "digest_valid_count");
`endif
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
- Upstream framing stage for the DES-S-box hash core.
- Accepts a host byte stream with valid/ready and an end-of-message flag, and buffers one whole message.
- Once the message is complete, drives the core's M_valid/message/counter interface with one byte per cycle and the exact byte length held stable.
- Waits for the core's hash_ready rising edge before accepting the next message.

Parameters:
ADDR_W, 6, buffer address width; buffer depth is 2**ADDR_W bytes (default 64).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  host byte/marker valid
in_ready  output  1  feeder can accept host beat
in_data  input  8  host message byte
in_last  input  1  beat is last of message
in_empty  input  1  with in_last: beat carries no byte (zero-length message or empty terminator)
M_valid  output  1  byte valid to hash core
message  output  8  byte to hash core
counter  output  64  message byte length to hash core, zero-extended
hash_ready  input  1  core digest-valid flag (level)
busy  output  1  message sent, digest pending
err_overflow  output  1  one-cycle pulse, message dropped (too long)

Behaviour:
- Reset: state FILL; wr_ptr, rd_ptr, len cleared; in_ready=0 during reset, then 1; M_valid=0, message=0, counter=0, busy=0, err_overflow=0, hash_ready_q=0.
- Accepted beat: in_valid & in_ready. Registered storage: one write per cycle.
- FILL: in_ready=1.
  - Accepted beat with in_empty=0 and count<DEPTH: byte written at wr_ptr; wr_ptr++.
  - Accepted beat with in_last=1: len = count of stored bytes, including this beat's byte if in_empty=0; next state SEND.
  - Accepted beat with in_empty=0 when count==DEPTH: err_overflow pulses for one cycle; buffer cleared.
    - If in_last=1 on that beat: stay in FILL.
    - Otherwise: go to DROP.
- DROP: in_ready=1; beats are sunk. Accepted in_last returns to FILL with pointers cleared. No M_valid is ever issued for a dropped message.
- SEND: in_ready=0.
  - counter=len, stable for the whole SEND.
  - M_valid=1 for exactly max(len,1) consecutive cycles; no gaps.
  - message=buf[rd_ptr]; rd_ptr increments each cycle.
  - len==0: a single M_valid cycle with message=0x00 and counter=0.
  - After the final cycle: M_valid=0 and go to WAIT.
  - message/counter hold their last values when M_valid=0.
- WAIT: in_ready=0, busy=1.
  - hash_ready_q <= hash_ready every cycle in all states.
  - Digest done when hash_ready & ~hash_ready_q; then go to FILL, clear pointers, busy=0 next cycle.
  - A level-high hash_ready left over from the previous message does not complete WAIT. The core clears it after the first M_valid, then raises it again.
- Buffer full with no in_last is never a stall; it always resolves to overflow.
- Back-to-back messages: the first beat of message N+1 is accepted no earlier than the cycle after the hash_ready rise for message N.
- Reset mid-SEND or mid-WAIT: immediate return to FILL; M_valid drops asynchronously with rst_n; buffer contents are discarded.
- Width rules:
  - count/len are ADDR_W+1 bits, so a length of exactly DEPTH is representable.
  - counter = {(63-ADDR_W)'b0, len}.
  - Pointers wrap modulo DEPTH but are cleared per message.

Optional Feature:
- Macro: HASH_FEEDER_DIGEST_LATCH_EN.
- When defined, three extra ports exist:
  - digest_in input 32: core digest_out.
  - digest_q output 32: registered digest.
  - digest_valid output 1: one-cycle pulse.
- When defined, the WAIT-exit cycle captures digest_in into digest_q and pulses digest_valid. digest_q holds until the next capture and resets to 0.
- When undefined, these ports and registers are absent; WAIT exit behaviour is otherwise identical.

Test Plan:
- "abc" (0x61,0x62,0x63; in_last on 0x63) -> M_valid high 3 consecutive cycles; message 0x61,0x62,0x63; counter=3 throughout; busy=1 until hash_ready rises; in_ready=0 in SEND/WAIT.
- Zero-length (in_valid, in_last=1, in_empty=1) -> single M_valid cycle, counter=0, message=0x00; core hash_ready rise returns to FILL.
- ADDR_W=2, 5-byte message 0x01..0x05 -> err_overflow one pulse on byte 5, M_valid never asserted, next 2-byte message 0xAA,0xBB sent with counter=2.
- Exactly DEPTH bytes (ADDR_W=2, 4 bytes, last on 4th) -> no overflow, 4 M_valid cycles, counter=4.
- Stale hash_ready=1 held while second message sent -> feeder stays in WAIT until hash_ready falls and rises again; with HASH_FEEDER_DIGEST_LATCH_EN, digest_q equals digest_in on the rising cycle and digest_valid pulses once.
- rst_n low for 1 cycle during the 2nd M_valid cycle of a 10-byte message -> M_valid=0 immediately, in_ready=1 after release; next message "x" (0x78) sent with counter=1.
